imm_ext_pipe: RTL and testbench

//   Pipelined, parametrised immediate-extension unit for the multi-cycle CPU datapath.

---
 rtl/imm_ext_pipe.sv | 111 +++++++++++
 tb/tb_imm_ext_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate extension unit (zero/sign/LUI/branch/jump) behind a valid/ready pipe.
// Optional illegal-mode flag: define IMM_ERR_EN to carry out_err through the pipe.
module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [JMP_W-1:0]  in_imm,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_err
);
    localparam int PCHI_W = DATA_W - JMP_W - 2;

    logic              vld_p1;
    logic              vld_p2;
    logic              adv1;
    logic              adv2;
    logic [JMP_W-1:0]  rawImm_p1;
    logic [2:0]        mode_p1;
    logic [PCHI_W-1:0] pcHi_p1;
    logic              unusedPcLo;

    function automatic logic [DATA_W-1:0] extendImm(
        input logic [JMP_W-1:0]  raw,
        input logic [2:0]        mode,
        input logic [PCHI_W-1:0] pcHi
    );
        logic signed [IMM_W-1:0]  imm;
        logic signed [DATA_W-1:0] sext;
        logic [DATA_W-1:0]        res;
        imm  = raw[IMM_W-1:0];
        sext = DATA_W'(imm);
        case (mode)
            3'd0:    res = {{(DATA_W-IMM_W){1'b0}}, imm};
            3'd1:    res = sext;
            3'd2:    res = {imm, {(DATA_W-IMM_W){1'b0}}};
            3'd3:    res = sext <<< 2;
            3'd4:    res = {pcHi, raw, 2'b00};
            default: res = '0;
        endcase
        return res;
    endfunction

    // A stage may load when its downstream neighbour is empty or draining this cycle.
    assign adv2      = !vld_p2 || out_ready;
    assign adv1      = !vld_p1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_p2;

    // Only the PC bits above the jump field reach the result.
    assign unusedPcLo = ^in_pc[JMP_W+1:0];

    // Stage S1: capture raw instruction fields
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            rawImm_p1 <= in_imm;
            mode_p1   <= in_mode;
            pcHi_p1   <= in_pc[DATA_W-1:JMP_W+2];
        end
    end

    // Stage S2: registered extended operand
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            out_imm <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_imm <= extendImm(rawImm_p1, mode_p1, pcHi_p1);
            end
        end
    end

`ifdef IMM_ERR_EN
    logic err_p2;

    function automatic logic isIllegal(input logic [2:0] mode);
        return mode > 3'd4;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_p2 <= 1'b0;
        end else if (adv2 && vld_p1) begin
            err_p2 <= isIllegal(mode_p1);
        end
    end

    assign out_err = err_p2;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: vector table through a scoreboard plus hand-timed pipeline sequences.
module tb_imm_ext_pipe;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int JMP_W  = 26;
`ifdef IMM_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [JMP_W-1:0]  in_imm;
    logic [2:0]        in_mode;
    logic [DATA_W-1:0] in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic              out_err;

    imm_ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .JMP_W(JMP_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [JMP_W-1:0]  imm;
        logic [2:0]        mode;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] expImm;
        logic              expErr;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] imm;
        logic              err;
    } exp_t;

    exp_t              sb[$];
    exp_t              popE;
    exp_t              pushE;
    vec_t              tbl[15];
    vec_t              vA, vB, vC;
    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] curExpImm = '0;
    logic              curExpErr = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_spurious actual=0x%08h required=no_output", out_imm);
                end else begin
                    popE = sb.pop_front();
                    check("sb_imm", out_imm, popE.imm);
                    check("sb_err", 32'(out_err), 32'(popE.err));
                end
            end
            if (in_valid && in_ready) begin
                pushE.imm = curExpImm;
                pushE.err = curExpErr;
                sb.push_back(pushE);
            end
        end
    end

    task automatic setVec(input vec_t v);
        in_valid  = 1'b1;
        in_imm    = v.imm;
        in_mode   = v.mode;
        in_pc     = v.pc;
        curExpImm = v.expImm;
        curExpErr = v.expErr;
    endtask

    task automatic drive(input vec_t v);
        bit ok;
        ok = 1'b0;
        setVec(v);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{26'h0008001, 3'd0 + 3'd1, 32'h0, 32'hFFFF8001, 1'b0};
        tbl[1]  = '{26'h0008001, 3'd0, 32'h0, 32'h00008001, 1'b0};
        tbl[2]  = '{26'h0001234, 3'd2, 32'h0, 32'h12340000, 1'b0};
        tbl[3]  = '{26'h000FFFF, 3'd3, 32'h0, 32'hFFFFFFFC, 1'b0};
        tbl[4]  = '{26'h0000004, 3'd4, 32'h40000014, 32'h40000010, 1'b0};
        tbl[5]  = '{26'h0000006, 3'd6, 32'h0, 32'h00000000, ERR_EXP};
        tbl[6]  = '{26'h0007FFF, 3'd1, 32'h0, 32'h00007FFF, 1'b0};
        tbl[7]  = '{26'h3FF8000, 3'd0, 32'h0, 32'h00008000, 1'b0};
        tbl[8]  = '{26'h0008000, 3'd3, 32'h0, 32'hFFFE0000, 1'b0};
        tbl[9]  = '{26'h0004000, 3'd3, 32'h0, 32'h00010000, 1'b0};
        tbl[10] = '{26'h3FFFFFF, 3'd4, 32'hF0000000, 32'hFFFFFFFC, 1'b0};
        tbl[11] = '{26'h000ABCD, 3'd5, 32'h0, 32'h00000000, ERR_EXP};
        tbl[12] = '{26'h0001234, 3'd7, 32'h0, 32'h00000000, ERR_EXP};
        tbl[13] = '{26'h3FFFFFF, 3'd2, 32'h0, 32'hFFFF0000, 1'b0};
        tbl[14] = '{26'h0000000, 3'd4, 32'h8FFFFFFF, 32'h80000000, 1'b0};

        // Reset held with in_valid asserted
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_imm    = 26'h0008001;
        in_mode   = 3'd1;
        in_pc     = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_imm", out_imm, 32'h0);
        end
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Latency: sign-ext then zero-ext on cycles +2 and +3
        setVec(tbl[0]);
        @(negedge clk);
        check("lat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        setVec(tbl[1]);
        @(negedge clk);
        check("lat_c1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_c2_valid", 32'(out_valid), 32'd1);
        check("lat_c2_imm", out_imm, 32'hFFFF8001);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_c3_valid", 32'(out_valid), 32'd1);
        check("lat_c3_imm", out_imm, 32'h00008001);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_c4_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        drain("lat_drain");

        // Vector table back-to-back at full throughput
        foreach (tbl[i]) drive(tbl[i]);
        in_valid = 1'b0;
        drain("tbl_drain");

        // Back-pressure: A and B fill the pipe, C must wait
        vA = '{26'h0000111, 3'd0, 32'h0, 32'h00000111, 1'b0};
        vB = '{26'h000F222, 3'd1, 32'h0, 32'hFFFFF222, 1'b0};
        vC = '{26'h0000333, 3'd2, 32'h0, 32'h03330000, 1'b0};
        out_ready = 1'b0;
        drive(vA);
        drive(vB);
        setVec(vC);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_hold_imm", out_imm, 32'h00000111);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pushpop_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_full_imm", out_imm, 32'hFFFFF222);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_last_imm", out_imm, 32'h03330000);
        @(posedge clk);
        #1;
        drain("bp_drain");

        // Mid-flight reset with two entries queued
        out_ready = 1'b0;
        drive(vA);
        drive(vB);
        in_valid = 1'b0;
        reset    = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_replay", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        drive(tbl[4]);
        in_valid = 1'b0;
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
